ptw_mem_arbiter: RTL and testbench

PTW_MEM_ARBITER -- requirements
Module: ptw_mem_arbiter

---
 rtl/sysconfig_pkg.sv | 15 +
 rtl/ptw_mem_arbiter.sv | 85 ++++++++
 tb/tb_ptw_mem_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/sysconfig_pkg.sv
// Shared system configuration: page-table-walk arbiter state encoding and
// requester identifiers used by the MMU memory path.
package sysconfig_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DRAIN = 2'd3
   } ptw_state_t;

   localparam logic REQ_IF = 1'b0;
   localparam logic REQ_LS = 1'b1;

endpackage

// File: rtl/ptw_mem_arbiter.sv
// Round-robin arbiter sharing one downstream read port between the IFU and LSU
// page-table walkers; one transaction outstanding, flush drops the in-flight PTE.
module ptw_mem_arbiter
   import sysconfig_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic              if_rvalid_o,
   input  logic              ls_req_i,
   input  logic [ADDR_W-1:0] ls_addr_i,
   output logic [DATA_W-1:0] ls_rdata_o,
   output logic              ls_rvalid_o,
   input  logic              flush_i,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_ready_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              mem_rvalid_i,
   output logic              busy_o
);

   ptw_state_t state, state_nxt;
   logic       grant, last_grant, cancel;
   logic       pick, start, deliver;

   // On a tie the requester that was not granted last wins.
   always_comb begin
      pick = REQ_LS;
      if (if_req_i && ls_req_i) pick = (last_grant == REQ_LS) ? REQ_IF : REQ_LS;
      else if (if_req_i)        pick = REQ_IF;
   end

   assign start   = (state == ST_IDLE) && !flush_i && (if_req_i || ls_req_i);
   assign deliver = (state == ST_WAIT) && mem_rvalid_i && !flush_i;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start) state_nxt = ST_ISSUE;
         ST_ISSUE: if (mem_ready_i) state_nxt = (cancel || flush_i) ? ST_DRAIN : ST_WAIT;
         ST_WAIT: begin
            if (mem_rvalid_i) state_nxt = ST_IDLE;
            else if (flush_i) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: if (mem_rvalid_i) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         grant      <= REQ_IF;
         last_grant <= REQ_LS;
         cancel     <= 1'b0;
         mem_addr_o <= '0;
      end else begin
         state <= state_nxt;
         if (start) begin
            grant      <= pick;
            last_grant <= pick;
            mem_addr_o <= (pick == REQ_IF) ? if_addr_i : ls_addr_i;
         end
         // The request stays on the bus once issued; a flush only marks it for drain.
         if (state == ST_ISSUE) begin
            if (mem_ready_i)  cancel <= 1'b0;
            else if (flush_i) cancel <= 1'b1;
         end
      end
   end

   assign mem_req_o   = (state == ST_ISSUE);
   assign busy_o      = (state != ST_IDLE);
   assign if_rvalid_o = deliver && (grant == REQ_IF);
   assign ls_rvalid_o = deliver && (grant == REQ_LS);
   assign if_rdata_o  = mem_rdata_i;
   assign ls_rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_ptw_mem_arbiter.sv
// Directed bench for ptw_mem_arbiter: expected PTE deliveries are queued when
// the downstream response is driven and popped when an rvalid_o pulse appears.
module tb_ptw_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req_i, ls_req_i, flush_i;
   logic [31:0] if_addr_i, ls_addr_i;
   logic [31:0] if_rdata_o, ls_rdata_o;
   logic        if_rvalid_o, ls_rvalid_o;
   logic        mem_req_o, mem_ready_i, mem_rvalid_i, busy_o;
   logic [31:0] mem_addr_o, mem_rdata_i;

   int checks = 0;
   int errors = 0;
   logic [32:0] sb[$];   // {is_ls, data}

   ptw_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_rvalid_o(if_rvalid_o),
      .ls_req_i(ls_req_i), .ls_addr_i(ls_addr_i), .ls_rdata_o(ls_rdata_o), .ls_rvalid_o(ls_rvalid_o),
      .flush_i(flush_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
      .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i),
      .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Response monitor: every rvalid_o pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      if (!rst && (if_rvalid_o || ls_rvalid_o)) begin
         logic [32:0] exp;
         logic [32:0] obs;
         obs = {ls_rvalid_o, ls_rvalid_o ? ls_rdata_o : if_rdata_o};
         checks++;
         assert (!(if_rvalid_o && ls_rvalid_o)) else begin
            errors++;
            $error("FAIL both_rvalid observed=11 expected=one-hot");
         end
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL spurious_rvalid observed=%0h expected=none", obs);
         end else begin
            exp = sb.pop_front();
            checks++;
            assert (obs === exp) else begin
               errors++;
               $error("FAIL rvalid_data observed=%0h expected=%0h", obs, exp);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_mem_req();
      int n = 0;
      while (!mem_req_o && n < 20) begin
         step();
         n++;
      end
      chk("mem_req_seen", mem_req_o, 1);
   endtask

   // Serve one walk read already requested; optionally deliver and drop the requester.
   task automatic serve(input logic [31:0] exp_addr, input int rdy_dly, input int rv_dly,
                        input logic [31:0] data, input logic exp_ls, input logic drop);
      wait_mem_req();
      chk("mem_addr", mem_addr_o, exp_addr);
      repeat (rdy_dly) begin
         step();
         chk("req_held", {mem_req_o, mem_addr_o}, {1'b1, exp_addr});
      end
      mem_ready_i = 1'b1;
      step();
      mem_ready_i = 1'b0;
      chk("wait_no_req", {busy_o, mem_req_o}, 2'b10);
      repeat (rv_dly - 1) step();
      sb.push_back({exp_ls, data});
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = data;
      step();
      mem_rvalid_i = 1'b0;
      if (drop) begin
         if (exp_ls) ls_req_i = 1'b0;
         else        if_req_i = 1'b0;
      end
   endtask

   initial begin
      rst = 1'b1;
      if_req_i = 0; ls_req_i = 0; flush_i = 0;
      if_addr_i = '0; ls_addr_i = '0;
      mem_ready_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
      step(); step();
      chk("rst_outputs", {mem_req_o, busy_o, if_rvalid_o, ls_rvalid_o}, 4'b0);
      chk("rst_addr", mem_addr_o, 32'h0);
      rst = 1'b0;
      step();

      // IFU alone, ready after one held cycle, rvalid three cycles into WAIT
      if_req_i = 1; if_addr_i = 32'h8000_1000;
      serve(32'h8000_1000, 1, 3, 32'hDEAD_BEEF, 1'b0, 1'b1);
      step();
      chk("idle_after_walk", busy_o, 0);

      // Both requests from reset, held for four back-to-back walks
      rst = 1'b1; step(); rst = 1'b0;
      if_req_i = 1; ls_req_i = 1;
      if_addr_i = 32'h1000_0008; ls_addr_i = 32'h2000_0010;
      serve(32'h1000_0008, 0, 1, 32'h1111_0001, 1'b0, 1'b0);
      serve(32'h2000_0010, 0, 1, 32'h2222_0002, 1'b1, 1'b0);
      serve(32'h1000_0008, 0, 2, 32'h1111_0003, 1'b0, 1'b0);
      serve(32'h2000_0010, 1, 1, 32'h2222_0004, 1'b1, 1'b0);
      if_req_i = 0; ls_req_i = 0;
      step();
      chk("idle_after_rr", busy_o, 0);

      // Flush pulse in ISSUE while not accepted: request held, then drained
      if_req_i = 1; if_addr_i = 32'h3000_0040;
      wait_mem_req();
      flush_i = 1; step(); flush_i = 0;
      chk("flush_req_held", {mem_req_o, mem_addr_o}, {1'b1, 32'h3000_0040});
      step();
      chk("flush_req_held2", mem_req_o, 1);
      mem_ready_i = 1; step(); mem_ready_i = 0;
      if_req_i = 0;
      chk("drain_entered", {busy_o, mem_req_o}, 2'b10);
      step(); step();
      chk("drain_waiting", busy_o, 1);
      mem_rvalid_i = 1; mem_rdata_i = 32'hBAD0_0001; step(); mem_rvalid_i = 0;
      chk("drain_done", busy_o, 0);

      // Flush coincident with response in WAIT, LSU pending behind IFU
      if_req_i = 1; if_addr_i = 32'h4000_0000;
      step();
      ls_req_i = 1; ls_addr_i = 32'h5000_0000;
      chk("if_issue", {mem_req_o, mem_addr_o}, {1'b1, 32'h4000_0000});
      mem_ready_i = 1; step(); mem_ready_i = 0;
      flush_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'hBAD0_0002;
      step();
      flush_i = 0; mem_rvalid_i = 0; if_req_i = 0;
      chk("flush_wait_idle", busy_o, 0);
      serve(32'h5000_0000, 0, 1, 32'h5555_AAAA, 1'b1, 1'b1);
      step();

      // Reset in WAIT abandons the walk; afterwards IFU wins the tie
      if_req_i = 1; if_addr_i = 32'h6000_0000;
      wait_mem_req();
      mem_ready_i = 1; step(); mem_ready_i = 0;
      chk("in_wait", busy_o, 1);
      rst = 1'b1; mem_rvalid_i = 1; mem_rdata_i = 32'hBAD0_0003; if_req_i = 0;
      #1;
      chk("rst_mid_outputs", {mem_req_o, busy_o, if_rvalid_o, ls_rvalid_o}, 4'b0);
      chk("rst_mid_addr", mem_addr_o, 32'h0);
      step();
      rst = 1'b0; mem_rvalid_i = 0;
      if_req_i = 1; ls_req_i = 1;
      if_addr_i = 32'h6100_0000; ls_addr_i = 32'h7100_0000;
      serve(32'h6100_0000, 0, 1, 32'h6161_6161, 1'b0, 1'b1);
      serve(32'h7100_0000, 0, 1, 32'h7171_7171, 1'b1, 1'b1);
      step();

      // Spurious downstream response while idle
      mem_rvalid_i = 1; mem_rdata_i = 32'hBAD0_0004; step(); mem_rvalid_i = 0;
      chk("spurious_idle", {busy_o, mem_req_o, if_rvalid_o, ls_rvalid_o}, 4'b0);
      step();
      chk("sb_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
